// File: rtl/lc3_alu_pipe.sv
// LC-3 style ALU with valid/ready handshake, registered result and NZP codes.
// Optional iterative shift-add multiplier (op 7) is built only when ALU_MUL_EN is defined.
module lc3_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             imm_sel,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    // Exactly one of N/Z/P is set for any value.
    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        logic [2:0] f;
        if (v == '0) begin
            f = 3'b010;
        end else if (v[WIDTH-1]) begin
            f = 3'b100;
        end else begin
            f = 3'b001;
        end
        return f;
    endfunction

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_nzp;
    logic [WIDTH-1:0] w_opb;
    logic [SH_W-1:0]  w_sh;
    logic [WIDTH-1:0] w_alu;
    logic             w_accept;
    logic             w_idle;
    logic             w_busy;

    assign w_opb    = imm_sel ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : b;
    assign w_sh     = w_opb[SH_W-1:0];
    assign in_ready = w_idle && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Single-cycle ALU result; op 7 yields zero here and is handled by the multiplier when present.
    always_comb begin
        w_alu = '0;
        case (op)
            OP_PASS: w_alu = a;
            OP_ADD:  w_alu = a + w_opb;
            OP_AND:  w_alu = a & w_opb;
            OP_NOT:  w_alu = ~a;
            OP_SUB:  w_alu = a - w_opb;
            OP_SHL:  w_alu = a << w_sh;
            OP_SRA:  w_alu = $signed(a) >>> w_sh;
            OP_MUL:  w_alu = '0;
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    assign w_idle    = (r_state == S_IDLE);
    assign w_busy    = (r_state == S_MUL);
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last    = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));

    // Multiplier control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Multiplier next-state: IDLE -> MUL on op 7, MUL -> DONE after WIDTH steps, DONE -> IDLE on handoff.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (op == OP_MUL)) begin
                    w_state_nxt = S_MUL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift-add datapath: one multiplier bit per cycle, low WIDTH bits of the product kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && (op == OP_MUL)) begin
            r_mcand  <= a;
            r_mplier <= w_opb;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
        end else begin
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_acc    <= r_acc;
            r_cnt    <= r_cnt;
        end
    end
`else
    assign w_idle = 1'b1;
    assign w_busy = 1'b0;
`endif

    // Output register: a new accept overrides the pending result so back-to-back ops see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_nzp       <= 3'b010;
`ifdef ALU_MUL_EN
        end else if (w_accept && (op == OP_MUL)) begin
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_result    <= w_acc_nxt;
            r_nzp       <= nzp_of(w_acc_nxt);
`endif
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu;
            r_nzp       <= nzp_of(w_alu);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign nzp       = r_nzp;
    assign busy      = w_busy;

endmodule

// File: tb/tb_lc3_alu_pipe.sv
// Self-checking bench for lc3_alu_pipe (WIDTH=16) with a cycle-level reference model.
// Runs against either build; MUL-specific checks are enabled when ALU_MUL_EN is defined.
module tb_lc3_alu_pipe;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'd0;
    logic          imm_sel = 1'b0;
    logic [4:0]    imm = 5'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [2:0]    nzp;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    lc3_alu_pipe #(.WIDTH(W), .IMM_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .imm_sel(imm_sel), .imm(imm), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .nzp(nzp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] m_nzpf(input logic [W-1:0] v);
        if (v == 16'h0000) return 3'b010;
        if ($signed(v) < 0) return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic [W-1:0] m_opb(input logic isel, input logic [4:0] im, input logic [W-1:0] bb);
        int iv;
        iv = (im >= 5'd16) ? int'(im) - 32 : int'(im);
        return isel ? W'(iv) : bb;
    endfunction

    function automatic logic [W-1:0] m_alu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int sh;
        sh = int'(y) % W;
        case (o)
            3'd0: return x;
            3'd1: return x + y;
            3'd2: return x & y;
            3'd3: return ~x;
            3'd4: return x - y;
            3'd5: return x << sh;
            3'd6: return W'($signed(x) >>> sh);
            default: return 16'h0000;
        endcase
    endfunction

    logic         m_valid;
    logic [W-1:0] m_result;
    logic [2:0]   m_nzp;
    int           m_left;
    logic [W-1:0] m_prod;
    logic         m_block;
    logic         m_rdy;

    assign m_rdy = !m_block && (!m_valid || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_result <= 16'h0000;
            m_nzp    <= 3'b010;
            m_left   <= 0;
            m_prod   <= 16'h0000;
            m_block  <= 1'b0;
        end else if (in_valid && m_rdy && op == 3'd7 && MUL_EN) begin
            m_valid <= 1'b0;
            m_left  <= W;
            m_prod  <= a * m_opb(imm_sel, imm, b);
            m_block <= 1'b1;
        end else if (in_valid && m_rdy) begin
            m_valid  <= 1'b1;
            m_result <= m_alu(op, a, m_opb(imm_sel, imm, b));
            m_nzp    <= m_nzpf(m_alu(op, a, m_opb(imm_sel, imm, b)));
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid  <= 1'b1;
                m_result <= m_prod;
                m_nzp    <= m_nzpf(m_prod);
            end
        end else if (out_ready && m_valid) begin
            m_valid <= 1'b0;
            m_block <= 1'b0;
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("in_ready", in_ready, m_rdy);
        chk("busy", busy, m_left != 0);
        if (m_valid || !rst_n) begin
            chk("result", result, m_result);
            chk("nzp", nzp, m_nzp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] o, input logic isel, input logic [4:0] im,
                           input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op = o; imm_sel = isel; imm = im; a = x; b = y;
    endtask

    task automatic req(input logic [2:0] o, input logic isel, input logic [4:0] im,
                       input logic [W-1:0] x, input logic [W-1:0] y);
        set_req(o, isel, im, x, y);
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_lit(input string nm, input logic [W-1:0] er, input logic [2:0] en);
        chk({nm, "_result"}, result, er);
        chk({nm, "_nzp"}, nzp, en);
        chk({nm, "_model"}, {m_result, m_nzp}, {er, en});
    endtask

    logic [2:0]   t_op  [10];
    logic         t_is  [10];
    logic [4:0]   t_im  [10];
    logic [W-1:0] t_a   [10];
    logic [W-1:0] t_b   [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        t_op[0]=3'd0; t_is[0]=1'b0; t_im[0]=5'h00; t_a[0]=16'hABCD; t_b[0]=16'h1111;
        t_op[1]=3'd1; t_is[1]=1'b0; t_im[1]=5'h00; t_a[1]=16'hFFFF; t_b[1]=16'h0001;
        t_op[2]=3'd2; t_is[2]=1'b0; t_im[2]=5'h00; t_a[2]=16'hF0F0; t_b[2]=16'h3C3C;
        t_op[3]=3'd3; t_is[3]=1'b0; t_im[3]=5'h00; t_a[3]=16'h00FF; t_b[3]=16'h1234;
        t_op[4]=3'd4; t_is[4]=1'b0; t_im[4]=5'h00; t_a[4]=16'h0000; t_b[4]=16'h0001;
        t_op[5]=3'd5; t_is[5]=1'b0; t_im[5]=5'h00; t_a[5]=16'h0001; t_b[5]=16'h000F;
        t_op[6]=3'd5; t_is[6]=1'b0; t_im[6]=5'h00; t_a[6]=16'h0003; t_b[6]=16'h0010;
        t_op[7]=3'd6; t_is[7]=1'b0; t_im[7]=5'h00; t_a[7]=16'h4000; t_b[7]=16'h001F;
        t_op[8]=3'd6; t_is[8]=1'b1; t_im[8]=5'h1F; t_a[8]=16'h8001; t_b[8]=16'h0000;
        t_op[9]=3'd1; t_is[9]=1'b1; t_im[9]=5'h0F; t_a[9]=16'h0001; t_b[9]=16'hFFFF;

        // reset state
        repeat (3) step();
        chk("rst_out_valid", out_valid, 1'b0);
        check_lit("rst", 16'h0000, 3'b010);
        rst_n = 1'b1;
        chk("in_ready_after_rst", in_ready, 1'b1);

        // directed literal vectors
        req(3'd1, 1'b1, 5'h01, 16'h7FFF, 16'h0000);
        check_lit("add_ovf", 16'h8000, 3'b100);
        req(3'd1, 1'b1, 5'h10, 16'h0010, 16'h0000);
        check_lit("add_immneg", 16'h0000, 3'b010);
        req(3'd6, 1'b0, 5'h00, 16'h8000, 16'h0013);
        check_lit("sra", 16'hF000, 3'b100);
        req(3'd4, 1'b0, 5'h00, 16'h0005, 16'h0007);
        check_lit("sub", 16'hFFFE, 3'b100);
        req(3'd5, 1'b0, 5'h00, 16'h0001, 16'h0014);
        check_lit("shl", 16'h0010, 3'b001);

        // back-to-back stream, model-checked each cycle
        for (int i = 0; i < 10; i++) begin
            set_req(t_op[i], t_is[i], t_im[i], t_a[i], t_b[i]);
            step();
        end
        in_valid = 1'b0;
        step();

        // backpressure then no-bubble replacement
        out_ready = 1'b0;
        req(3'd1, 1'b0, 5'h00, 16'h1234, 16'h0001);
        set_req(3'd4, 1'b0, 5'h00, 16'h0003, 16'h0005);
        for (int i = 0; i < 5; i++) begin
            step();
            check_lit("hold", 16'h1235, 3'b001);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_lit("nobubble", 16'hFFFE, 3'b100);
        chk("nobubble_valid", out_valid, 1'b1);
        step();

`ifdef ALU_MUL_EN
        req(3'd7, 1'b0, 5'h00, 16'd300, 16'd300);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            chk("mul_busy", busy, 1'b1);
            chk("mul_in_ready", in_ready, 1'b0);
            step();
            cyc++;
        end
        chk("mul_latency", cyc, 16);
        check_lit("mul", 16'h5F90, 3'b001);
        step();
        req(3'd7, 1'b1, 5'h1D, 16'h0007, 16'h0000);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk("mul2_latency", cyc, 16);
        check_lit("mul_imm", 16'hFFEB, 3'b100);
        step();

        // reset in the middle of a multiply
        req(3'd7, 1'b0, 5'h00, 16'd300, 16'd300);
        repeat (7) step();
        chk("midmul_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_valid", out_valid, 1'b0);
        chk("midmul_rst_busy", busy, 1'b0);
        chk("midmul_rst_nzp", nzp, 3'b010);
        step();
        rst_n = 1'b1;
        chk("midmul_in_ready", in_ready, 1'b1);
`else
        req(3'd7, 1'b0, 5'h00, 16'h1234, 16'h5678);
        check_lit("op7_nomul", 16'h0000, 3'b010);
        chk("op7_valid", out_valid, 1'b1);
        chk("op7_busy", busy, 1'b0);
        step();

        // asynchronous reset while a result is held
        out_ready = 1'b0;
        req(3'd0, 1'b0, 5'h00, 16'h8123, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", out_valid, 1'b0);
        chk("rst_hold_nzp", nzp, 3'b010);
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        chk("rst_hold_in_ready", in_ready, 1'b1);
`endif
        req(3'd2, 1'b1, 5'h1F, 16'h5A5A, 16'h0000);
        check_lit("and_imm", 16'h5A5A, 3'b001);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
